rst_seq_gen: RTL and testbench

- Parametrised successor to the two-flop synchronous reset generator.
- Asserts resets asynchronously and releases them synchronously through a configurable-depth synchronizer.
- After release, stretches the reset by a programmable hold count, then deasserts NUM_OUT active-low reset outputs in sequence, spaced STEP_CYCLES apart.
- Sits at the top level between the board reset and the per-block resets (PHY/TX path, MAC, packet generator) so blocks leave reset in a fixed order.

---
 rtl/rst_seq_pkg.sv | 22 ++
 rtl/rst_sync.sv | 29 ++
 rtl/rst_seq_gen.sv | 130 +++++++++++++
 tb/tb_rst_seq_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the sequenced reset generator.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD,
    STEP,
    DONE
  } seq_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_NUM_OUT     = 3;
  localparam int DEF_STEP_CYCLES = 2;

  // Width needed to hold max(a, b); never narrower than one bit.
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Async-assert, sync-release reset synchronizer; sync_ok is the last stage,
// sync_pre the stage feeding it (high one clock before sync_ok).
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_res,
  output logic sync_ok,
  output logic sync_pre
);

  if (SYNC_STAGES < 2) begin : g_param_err
    $error("rst_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok  = chain[SYNC_STAGES-1];
  assign sync_pre = chain[SYNC_STAGES-2];

endmodule

// File: rtl/rst_seq_gen.sv
// Sequenced reset generator: synchronised release, hold stretch, then ordered
// release of NUM_OUT active-low resets. Optional software reset: RST_SEQ_SWRST_EN.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int NUM_OUT     = DEF_NUM_OUT,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic               i_clk,
  input  logic               i_res,
`ifdef RST_SEQ_SWRST_EN
  input  logic               i_sw_rst,
`endif
  output logic [NUM_OUT-1:0] o_res_n,
  output logic               o_done
);

  if (SYNC_STAGES < 2 || NUM_OUT < 1 || STEP_CYCLES < 1 || HOLD_CYCLES < 0) begin : g_param_err
    $error("rst_seq_gen: illegal parameter combination");
  end

  localparam int CNT_W = clog2_max(HOLD_CYCLES, STEP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  seq_state_t         state_q, state_next;
  logic [CNT_W-1:0]   cnt_q, cnt_next;
  logic [NUM_OUT-1:0] res_n_next;
  logic [NUM_OUT-1:0] res_n_shift;
  logic               done_next;
  logic               sync_ok;
  logic               sync_pre;
  logic               hold_release;
  logic               sw_clear;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_res   (i_res),
    .sync_ok (sync_ok),
    .sync_pre(sync_pre)
  );

`ifdef RST_SEQ_SWRST_EN
  assign sw_clear = i_sw_rst;
`else
  assign sw_clear = 1'b0;
`endif

  // Bits release strictly in order, so shifting a 1 in from bit 0 stands in
  // for an explicit release index.
  if (NUM_OUT == 1) begin : g_one
    assign res_n_shift = 1'b1;
  end else begin : g_many
    assign res_n_shift = {o_res_n[NUM_OUT-2:0], 1'b1};
  end

  // A zero hold releases on the edge sync_ok itself rises, so look one stage early.
  assign hold_release = (HOLD_CYCLES == 0) ? sync_pre : (sync_ok && (cnt_q == HOLD_LAST));

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      o_res_n <= '0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_next;
      cnt_q   <= cnt_next;
      o_res_n <= res_n_next;
      o_done  <= done_next;
    end
  end

  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    res_n_next = o_res_n;
    done_next  = o_done;

    case (state_q)
      HOLD: begin
        if (hold_release) begin
          cnt_next   = '0;
          res_n_next = res_n_shift;
          if (res_n_shift[NUM_OUT-1]) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = STEP;
          end
        end else if (sync_ok) begin
          cnt_next = cnt_q + CNT_W'(1);
        end else begin
          cnt_next = '0;
        end
      end
      STEP: begin
        if (cnt_q == STEP_LAST) begin
          cnt_next   = '0;
          res_n_next = res_n_shift;
          if (res_n_shift[NUM_OUT-1]) begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        done_next = 1'b1;
      end
      default: begin
        state_next = HOLD;
        cnt_next   = '0;
      end
    endcase

    if (sw_clear) begin
      state_next = HOLD;
      cnt_next   = '0;
      res_n_next = '0;
      done_next  = 1'b0;
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed, table-driven bench for rst_seq_gen (default and short-hold builds).
module tb_rst_seq_gen;

  logic       i_clk;
  logic       i_res;
`ifdef RST_SEQ_SWRST_EN
  logic       i_sw_rst;
`endif
  logic [2:0] res_n;
  logic       done;
  logic [0:0] res_n2;
  logic       done2;

  int errors;
  int checks;

  typedef struct {
    int         edge_no;
    logic [2:0] res_n;
    logic       done;
    logic       res_n2;
    logic       done2;
  } vec_t;

  vec_t vec[11];

  rst_seq_gen #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(4),
    .NUM_OUT    (3),
    .STEP_CYCLES(2)
  ) dut (
    .i_clk   (i_clk),
    .i_res   (i_res),
`ifdef RST_SEQ_SWRST_EN
    .i_sw_rst(i_sw_rst),
`endif
    .o_res_n (res_n),
    .o_done  (done)
  );

  rst_seq_gen #(
    .SYNC_STAGES(3),
    .HOLD_CYCLES(0),
    .NUM_OUT    (1),
    .STEP_CYCLES(2)
  ) dut2 (
    .i_clk   (i_clk),
    .i_res   (i_res),
`ifdef RST_SEQ_SWRST_EN
    .i_sw_rst(i_sw_rst),
`endif
    .o_res_n (res_n2),
    .o_done  (done2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [2:0] exp_res_n, input logic exp_done,
                             input logic exp_res2, input logic exp_done2);
    checks++;
    if (res_n !== exp_res_n || done !== exp_done) begin
      errors++;
      $display("[TB] FAIL %s main: got res_n=%b done=%b, expected res_n=%b done=%b",
               name, res_n, done, exp_res_n, exp_done);
    end
    checks++;
    if (res_n2 !== exp_res2 || done2 !== exp_done2) begin
      errors++;
      $display("[TB] FAIL %s short: got res_n=%b done=%b, expected res_n=%b done=%b",
               name, res_n2, done2, exp_res2, exp_done2);
    end
  endtask

  // Walks the first 'count' table rows, one rising edge per row.
  task automatic runEdges(input string tag, input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge i_clk);
      #1;
      checkOutput($sformatf("%s_e%0d", tag, vec[i].edge_no),
                  vec[i].res_n, vec[i].done, vec[i].res_n2, vec[i].done2);
    end
  endtask

  task automatic applyStimulus(input string tag, input int hold_clocks);
    @(negedge i_clk);
    i_res = 1'b1;
    repeat (hold_clocks) @(posedge i_clk);
    #1;
    checkOutput({tag, "_in_reset"}, 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_res = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    i_res  = 1'b1;
`ifdef RST_SEQ_SWRST_EN
    i_sw_rst = 1'b0;
`endif

    vec[0]  = '{1,  3'b000, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{2,  3'b000, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{3,  3'b000, 1'b0, 1'b1, 1'b1};
    vec[3]  = '{4,  3'b000, 1'b0, 1'b1, 1'b1};
    vec[4]  = '{5,  3'b000, 1'b0, 1'b1, 1'b1};
    vec[5]  = '{6,  3'b001, 1'b0, 1'b1, 1'b1};
    vec[6]  = '{7,  3'b001, 1'b0, 1'b1, 1'b1};
    vec[7]  = '{8,  3'b011, 1'b0, 1'b1, 1'b1};
    vec[8]  = '{9,  3'b011, 1'b0, 1'b1, 1'b1};
    vec[9]  = '{10, 3'b111, 1'b1, 1'b1, 1'b1};
    vec[10] = '{11, 3'b111, 1'b1, 1'b1, 1'b1};

    $display("[TB] power-on sequence");
    applyStimulus("pwr", 3);
    runEdges("pwr", 11);

    $display("[TB] async reset mid-sequence");
    applyStimulus("mid", 3);
    runEdges("mid", 7);
    #1;
    i_res = 1'b1;
    #1;
    checkOutput("mid_async_clear", 3'b000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_res = 1'b0;
    runEdges("mid_replay", 11);

    $display("[TB] short reset glitch in DONE");
    @(posedge i_clk);
    #2;
    i_res = 1'b1;
    #1;
    i_res = 1'b0;
    #1;
    checkOutput("glitch_clear", 3'b000, 1'b0, 1'b0, 1'b0);
    runEdges("glitch_replay", 11);

`ifdef RST_SEQ_SWRST_EN
    $display("[TB] software reset from DONE");
    @(negedge i_clk);
    i_sw_rst = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("sw_first_edge", 3'b000, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    checkOutput("sw_last_edge", 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_sw_rst = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      @(posedge i_clk);
      #1;
      checkOutput($sformatf("sw_n%0d", j), {(j >= 8), (j >= 6), (j >= 4)}, (j >= 8), 1'b1, 1'b1);
    end

    $display("[TB] software reset during hardware reset");
    @(negedge i_clk);
    i_res    = 1'b1;
    i_sw_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("sw_in_res", 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_sw_rst = 1'b0;
    @(negedge i_clk);
    i_res = 1'b0;
    runEdges("sw_in_res_seq", 11);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
